switch_pio_edge_ctrl: RTL and testbench

Controller for the slide-switch input port. It synchronizes and debounces the raw switch lines, captures edges, and raises a maskable interrupt. State is exposed to the Nios II through an Avalon-MM slave with the same 4-word map and registered-read timing as the plain switch PIO it replaces. It sits between the board switch pins and the system interconnect.

---
 rtl/switch_pio_edge_ctrl.sv | 134 +++++++++++++
 tb/tb_switch_pio_edge_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/switch_pio_edge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : switch_pio_edge_ctrl
// Brief    : Slide-switch PIO with sync, per-bit debounce, edge capture, irq.
// Revision : 1.0
// ============================================================================
module switch_pio_edge_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      rd_mux;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in_port;
            sync_q2 <= sync_q1;
        end
    end

    // A line is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_q2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign ev = rise;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign ev = fall;
        end else begin : g_edge_any
            assign ev = rise | fall;
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // New events take priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | ev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_switch_pio_edge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_pio_edge_ctrl
// Brief    : Directed + randomized bench with a sliding-window reference model.
// Revision : 1.0
// ============================================================================
module tb_switch_pio_edge_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] readdata2;
    logic        irq2;

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    switch_pio_edge_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(16), .EDGE_TYPE(2)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    switch_pio_edge_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(16), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata2), .irq(irq2)
    );

    // Reference model: a line flips once the last D synchronized samples all
    // disagree with it; samples are the in_port values seen at each edge.
    logic [7:0]  hs [0:D+1];
    logic [7:0]  m_stab, m_chg, m_cap, m_cap2, m_mask, m_clr, m_next;
    logic [31:0] m_rd, m_rd2;
    bit          all_diff;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int j = 0; j <= D + 1; j++) hs[j] = 8'h00;
            m_stab = 8'h00; m_chg = 8'h00; m_cap = 8'h00; m_cap2 = 8'h00;
            m_mask = 8'h00; m_rd = 32'h0; m_rd2 = 32'h0;
        end else begin
            case (address)
                2'd0:    begin m_rd = {24'h0, m_stab}; m_rd2 = {24'h0, m_stab}; end
                2'd2:    begin m_rd = {24'h0, m_mask}; m_rd2 = {24'h0, m_mask}; end
                2'd3:    begin m_rd = {24'h0, m_cap};  m_rd2 = {24'h0, m_cap2}; end
                default: begin m_rd = 32'h0; m_rd2 = 32'h0; end
            endcase
            m_clr  = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
            m_cap  = (m_cap  & ~m_clr) | m_chg;
            m_cap2 = (m_cap2 & ~m_clr) | (m_chg & m_stab);
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
            for (int j = D + 1; j >= 1; j--) hs[j] = hs[j-1];
            hs[0] = in_port;
            m_next = m_stab;
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (hs[j][i] == m_stab[i]) all_diff = 1'b0;
                if (all_diff) m_next[i] = ~m_stab[i];
            end
            m_chg  = m_next ^ m_stab;
            m_stab = m_next;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking && reset_n) begin
            chk("model_readdata", readdata, m_rd);
            chk("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
            chk("model_readdata_rise", readdata2, m_rd2);
            chk("model_irq_rise", {31'h0, irq2}, {31'h0, |(m_cap2 & m_mask)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; in_port = 8'h00; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        tick(3);
        reset_n = 1'b1;
        checking = 1'b1;

        rd(2'd0); chk("reset_rd0", readdata, 32'h0);
        rd(2'd1); chk("reset_rd1", readdata, 32'h0);
        rd(2'd2); chk("reset_rd2", readdata, 32'h0);
        rd(2'd3); chk("reset_rd3", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // Reset in the middle of a count must restart the full latency.
        in_port = 8'hFF; tick(4);
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
        address = 2'd0;
        tick(6); chk("midreset_not_yet", readdata, 32'h0);
        tick(1); chk("midreset_settled", readdata, 32'hFF);
        in_port = 8'h00; tick(8); wr(2'd3, 32'hFF);

        in_port = 8'h05; address = 2'd0;
        tick(6); chk("debounce_pre", readdata, 32'h0);
        tick(1); chk("debounce_05", readdata, 32'h5);
        wr(2'd3, 32'hFF);
        in_port = 8'h85; tick(3); in_port = 8'h05; tick(10);
        rd(2'd0); chk("glitch_stable", readdata, 32'h5);
        rd(2'd3); chk("glitch_capture", readdata, 32'h0);
        chk("glitch_irq", {31'h0, irq}, 32'h0);

        in_port = 8'h04; tick(8); wr(2'd3, 32'hFF);
        wr(2'd2, 32'h1);
        in_port = 8'h05; tick(8);
        rd(2'd3); chk("mask_capture", readdata, 32'h1);
        chk("mask_irq_high", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        chk("w1c_irq_low", {31'h0, irq}, 32'h0);
        rd(2'd3); chk("w1c_capture", readdata, 32'h0);
        in_port = 8'h01; tick(8);
        rd(2'd3); chk("masked_capture", readdata, 32'h4);
        chk("masked_irq", {31'h0, irq}, 32'h0);
        wr(2'd3, 32'hFF);

        // Clear lands on the same edge the falling event of bit0 is captured.
        in_port = 8'h00; tick(6);
        wr(2'd3, 32'h1);
        rd(2'd3); chk("set_wins", readdata, 32'h1);
        chk("set_wins_irq", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'hFF);

        in_port = 8'h05; tick(8); wr(2'd3, 32'hFF);
        wr(2'd0, 32'hFFFFFFFF); wr(2'd1, 32'hFFFFFFFF);
        rd(2'd0); chk("ignored_wr0", readdata, 32'h5);
        rd(2'd1); chk("ignored_wr1", readdata, 32'h0);
        wr(2'd2, 32'hFFFFFF00);
        rd(2'd2); chk("mask_upper_ignored", readdata, 32'h0);

        in_port = 8'h0D; tick(8); wr(2'd3, 32'hFF);
        in_port = 8'h05; tick(8);
        rd(2'd3); chk("rise_only_fall", readdata2, 32'h0);
        chk("any_edge_fall", readdata, 32'h8);
        in_port = 8'h0D; tick(8);
        rd(2'd3); chk("rise_only_rise", readdata2, 32'h8);
        chk("model_pin_stable", {24'h0, m_stab}, 32'h0D);
        chk("model_pin_cap2", {24'h0, m_cap2}, 32'h08);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) in_port = 8'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0; tick(2); reset_n = 1'b1;
            end
            tick(1);
        end
        chipselect = 1'b0; write_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
